ps2_key_controller: RTL and testbench

Sequences PS/2 set-2 scan-code bytes from the keyboard frame receiver into ASCII key events for the CPU. Tracks make, break (0xF0) and extended (0xE0) prefixes plus shift state, maps make codes to ASCII, and buffers the characters in a first-word-fall-through FIFO. The FIFO is drained by a valid/acknowledge handshake on the system clock. Sits between the PS/2 byte receiver (already synchronised to `clk`) and the memory-mapped keyboard port.

---
 rtl/ps2_key_controller.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ps2_key_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_controller.sv
// ---------------------------------------------------------------------------
// ps2_key_controller
//
// Converts PS/2 set-2 scan-code bytes into ASCII key events. A small decoder
// FSM tracks the break (0xF0) and extended (0xE0) prefixes. Mapped make codes
// are translated to ASCII and written into a first-word-fall-through FIFO.
// The CPU drains the FIFO with a valid/acknowledge handshake.
//
// Optional feature: define PS2_KBD_SHIFT_EN to track the shift keys
// (0x12 / 0x59). Letters are then lowercase unless shift is held, and digits
// map to their shifted symbols while shift is held. Without the macro,
// letters are always uppercase, digits are always digits, and shiftActive
// is tied to 0.
//
// Parameters
//   DEPTH      FIFO entries, power of two, 2..64
//   WORD_SIZE  width of rdData (>= 8); the character is zero-extended
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   inValid      one-cycle strobe, a received byte is on inByte
//   inByte       received scan-code byte
//   inError      qualifies inValid: parity/framing error, byte is dropped
//   rdValid      FIFO not empty, rdData holds the oldest character
//   rdData       oldest character, zero-extended (0 when empty)
//   rdAck        pops the head, ignored when rdValid = 0
//   count        current FIFO occupancy, 0..DEPTH
//   errSticky    set by an inError byte
//   ovfSticky    set when a character is dropped on a full FIFO
//   errClr       clears both sticky flags (a same-cycle set wins)
//   shiftActive  current shift state
// ---------------------------------------------------------------------------

package gc;
  parameter int WORD_SIZE = 16;
endpackage

module ps2_key_controller #(
  parameter int DEPTH     = 8,
  parameter int WORD_SIZE = gc::WORD_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  input  logic [7:0]               inByte,
  input  logic                     inError,
  output logic                     rdValid,
  output logic [WORD_SIZE-1:0]     rdData,
  input  logic                     rdAck,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     errSticky,
  output logic                     ovfSticky,
  input  logic                     errClr,
  output logic                     shiftActive
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BRK    = 2'd1;
  localparam logic [1:0] ST_EXT    = 2'd2;
  localparam logic [1:0] ST_EXTBRK = 2'd3;

  // Base translation: uppercase letters, plain digits, control characters.
  // A return value of 0 marks an unmapped code.
  function automatic logic [7:0] map_code(input logic [7:0] code);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = 8'h41; 8'h32: ch = 8'h42; 8'h21: ch = 8'h43;
      8'h23: ch = 8'h44; 8'h24: ch = 8'h45; 8'h2B: ch = 8'h46;
      8'h34: ch = 8'h47; 8'h33: ch = 8'h48; 8'h43: ch = 8'h49;
      8'h3B: ch = 8'h4A; 8'h42: ch = 8'h4B; 8'h4B: ch = 8'h4C;
      8'h3A: ch = 8'h4D; 8'h31: ch = 8'h4E; 8'h44: ch = 8'h4F;
      8'h4D: ch = 8'h50; 8'h15: ch = 8'h51; 8'h2D: ch = 8'h52;
      8'h1B: ch = 8'h53; 8'h2C: ch = 8'h54; 8'h3C: ch = 8'h55;
      8'h2A: ch = 8'h56; 8'h1D: ch = 8'h57; 8'h22: ch = 8'h58;
      8'h35: ch = 8'h59; 8'h1A: ch = 8'h5A;
      8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32;
      8'h26: ch = 8'h33; 8'h25: ch = 8'h34; 8'h2E: ch = 8'h35;
      8'h36: ch = 8'h36; 8'h3D: ch = 8'h37; 8'h3E: ch = 8'h38;
      8'h46: ch = 8'h39;
      8'h29: ch = 8'h20; 8'h5A: ch = 8'h0D; 8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

`ifdef PS2_KBD_SHIFT_EN
  // Applies the shift state to a base character.
  function automatic logic [7:0] apply_shift(input logic [7:0] ch,
                                             input logic       shift);
    logic [7:0] res;
    res = ch;
    if (ch >= 8'h41 && ch <= 8'h5A) begin
      if (!shift) res = ch + 8'h20;
    end else if (ch >= 8'h30 && ch <= 8'h39 && shift) begin
      case (ch)
        8'h30:   res = 8'h29;  // )
        8'h31:   res = 8'h21;  // !
        8'h32:   res = 8'h40;  // @
        8'h33:   res = 8'h23;  // #
        8'h34:   res = 8'h24;  // $
        8'h35:   res = 8'h25;  // %
        8'h36:   res = 8'h5E;  // ^
        8'h37:   res = 8'h26;  // &
        8'h38:   res = 8'h2A;  // *
        default: res = 8'h28;  // (
      endcase
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
`ifdef PS2_KBD_SHIFT_EN
  logic          shift_q, shift_d;
  logic          brk_vld;
  logic          is_shift;
`endif

  // ---------------------------------------------------------------------
  // Decoder FSM
  // ---------------------------------------------------------------------
  logic       make_vld;
  logic [7:0] base_ch;
  logic [7:0] push_ch;
  logic       push_req;

  always_comb begin
    state_d  = state_q;
    make_vld = 1'b0;
`ifdef PS2_KBD_SHIFT_EN
    brk_vld  = 1'b0;
`endif
    if (inValid) begin
      if (inError) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (inByte == 8'hE0)      state_d = ST_EXT;
            else if (inByte == 8'hF0) state_d = ST_BRK;
            else                      make_vld = 1'b1;
          end
          ST_BRK: begin
`ifdef PS2_KBD_SHIFT_EN
            brk_vld = 1'b1;
`endif
            state_d = ST_IDLE;
          end
          ST_EXT: begin
            state_d = (inByte == 8'hF0) ? ST_EXTBRK : ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Character generation; shift_q is the state before this byte, which is
  // correct because a character-producing make never changes shift.
  always_comb begin
    base_ch = map_code(inByte);
`ifdef PS2_KBD_SHIFT_EN
    is_shift = (inByte == 8'h12) || (inByte == 8'h59);
    push_ch  = apply_shift(base_ch, shift_q);
    shift_d  = shift_q;
    if (make_vld && is_shift) shift_d = 1'b1;
    if (brk_vld && is_shift)  shift_d = 1'b0;
`else
    push_ch  = base_ch;
`endif
    push_req = make_vld && (base_ch != 8'h00);
  end

  // ---------------------------------------------------------------------
  // FIFO and sticky flags
  // ---------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic ovf_evt;
  logic err_evt;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    do_pop     = rdAck && !fifo_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    do_push    = push_req && (!fifo_full || do_pop);
    ovf_evt    = push_req && fifo_full && !do_pop;
    err_evt    = inValid && inError;

    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_ch;

    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);

    err_d = err_evt || (err_q && !errClr);
    ovf_d = ovf_evt || (ovf_q && !errClr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef PS2_KBD_SHIFT_EN
      shift_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
`ifdef PS2_KBD_SHIFT_EN
      shift_q  <= shift_d;
`endif
    end
  end

  // Storage needs no reset: rdData is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    rdValid   = !fifo_empty;
    rdData    = fifo_empty ? '0 : WORD_SIZE'(mem_q[rd_ptr_q]);
    count     = count_q;
    errSticky = err_q;
    ovfSticky = ovf_q;
`ifdef PS2_KBD_SHIFT_EN
    shiftActive = shift_q;
`else
    shiftActive = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ps2_key_controller.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_controller
//
// Self-checking bench for ps2_key_controller: a table of single-cycle
// vectors, hand-written multi-cycle sequences, and a randomized phase
// compared against a queue-based reference model.
// ---------------------------------------------------------------------------

module tb_ps2_key_controller;

  localparam int DEPTH = 8;
  localparam int WS    = 16;

`ifdef PS2_KBD_SHIFT_EN
  localparam int  LC       = 32'h20;
  localparam bit  SHIFT_EN = 1'b1;
`else
  localparam int  LC       = 0;
  localparam bit  SHIFT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 inValid = 1'b0;
  logic [7:0]           inByte = 8'h00;
  logic                 inError = 1'b0;
  logic                 rdValid;
  logic [WS-1:0]        rdData;
  logic                 rdAck = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                 errSticky;
  logic                 ovfSticky;
  logic                 errClr = 1'b0;
  logic                 shiftActive;

  int n_checks = 0;
  int n_errors = 0;

  ps2_key_controller #(.DEPTH(DEPTH), .WORD_SIZE(WS)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inByte(inByte),
    .inError(inError), .rdValid(rdValid), .rdData(rdData), .rdAck(rdAck),
    .count(count), .errSticky(errSticky), .ovfSticky(ovfSticky),
    .errClr(errClr), .shiftActive(shiftActive)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the next negedge.
  task automatic drive(input logic v, input logic [7:0] b, input logic e,
                       input logic a, input logic c);
    inValid = v; inByte = b; inError = e; rdAck = a; errClr = c;
    @(negedge clk);
    inValid = 1'b0; inByte = 8'h00; inError = 1'b0; rdAck = 1'b0;
    errClr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: prefix flags, queue FIFO, lookup tables
  // ---------------------------------------------------------------------
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] shifted_digits [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24,
    8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

  logic [7:0] m_q [$];
  bit m_brk, m_ext, m_shift, m_err, m_ovf;

  function automatic bit model_char(input logic [7:0] code, input bit shift,
                                    output logic [7:0] ch);
    ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) begin
        ch = 8'h41 + 8'(i);
        if (SHIFT_EN && !shift) ch = ch + 8'h20;
        return 1'b1;
      end
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) begin
        ch = (SHIFT_EN && shift) ? shifted_digits[i] : 8'h30 + 8'(i);
        return 1'b1;
      end
    if (code == 8'h29) begin ch = 8'h20; return 1'b1; end
    if (code == 8'h5A) begin ch = 8'h0D; return 1'b1; end
    if (code == 8'h66) begin ch = 8'h08; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_brk = 0; m_ext = 0; m_shift = 0; m_err = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b,
                            input logic e, input logic a, input logic c);
    bit pop, has_ch, err_set, ovf_set, is_sh;
    logic [7:0] ch;
    pop = a && (m_q.size() > 0);
    has_ch = 0; err_set = 0; ovf_set = 0; ch = 8'h00;
    is_sh = (b == 8'h12) || (b == 8'h59);
    if (v && e) begin
      err_set = 1; m_brk = 0; m_ext = 0;
    end else if (v) begin
      if (!m_brk && !m_ext) begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (is_sh) begin
          if (SHIFT_EN) m_shift = 1;
        end else has_ch = model_char(b, m_shift, ch);
      end else if (m_brk && !m_ext) begin
        if (is_sh && SHIFT_EN) m_shift = 0;
        m_brk = 0;
      end else if (m_ext && !m_brk) begin
        if (b == 8'hF0) m_brk = 1; else m_ext = 0;
      end else begin
        m_brk = 0; m_ext = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (has_ch) begin
      if (m_q.size() < DEPTH) m_q.push_back(ch);
      else ovf_set = 1;
    end
    m_err = err_set || (m_err && !c);
    m_ovf = ovf_set || (m_ovf && !c);
  endtask

  task automatic compare_model();
    check("rnd_count", int'(count), m_q.size());
    check("rnd_rdValid", int'(rdValid), int'(m_q.size() > 0));
    check("rnd_rdData", int'(rdData), (m_q.size() > 0) ? int'(m_q[0]) : 0);
    check("rnd_errSticky", int'(errSticky), int'(m_err));
    check("rnd_ovfSticky", int'(ovfSticky), int'(m_ovf));
    check("rnd_shift", int'(shiftActive), int'(m_shift));
  endtask

  // ---------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       e;
    logic       a;
    int         cnt;
    int         head;   // -1: FIFO expected empty
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs = '{
      '{1'b1, 8'h1C, 1'b0, 1'b0, 1, 32'h41 + LC},
      '{1'b1, 8'hF0, 1'b0, 1'b0, 1, 32'h41 + LC},
      '{1'b1, 8'h1C, 1'b0, 1'b0, 1, 32'h41 + LC},
      '{1'b1, 8'h32, 1'b0, 1'b0, 2, 32'h41 + LC},
      '{1'b1, 8'hE0, 1'b0, 1'b0, 2, 32'h41 + LC},
      '{1'b1, 8'h75, 1'b0, 1'b0, 2, 32'h41 + LC},
      '{1'b1, 8'h45, 1'b0, 1'b0, 3, 32'h41 + LC},
      '{1'b1, 8'h0E, 1'b0, 1'b0, 3, 32'h41 + LC},
      '{1'b1, 8'h29, 1'b1, 1'b0, 3, 32'h41 + LC},
      '{1'b1, 8'h5A, 1'b0, 1'b0, 4, 32'h41 + LC},
      '{1'b1, 8'hF0, 1'b0, 1'b0, 4, 32'h41 + LC},
      '{1'b1, 8'h5A, 1'b0, 1'b0, 4, 32'h41 + LC},
      '{1'b1, 8'h66, 1'b0, 1'b1, 4, 32'h42 + LC},
      '{1'b0, 8'h00, 1'b0, 1'b1, 3, 32'h30},
      '{1'b0, 8'h00, 1'b0, 1'b1, 2, 32'h0D},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1, 32'h08},
      '{1'b0, 8'h00, 1'b0, 1'b1, 0, -1},
      '{1'b0, 8'h00, 1'b0, 1'b1, 0, -1},
      '{1'b1, 8'h29, 1'b0, 1'b0, 1, 32'h20},
      '{1'b0, 8'h00, 1'b0, 1'b1, 0, -1}
    };

    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_count", int'(count), 0);
    check("rst_rdValid", int'(rdValid), 0);
    check("rst_rdData", int'(rdData), 0);
    check("rst_errSticky", int'(errSticky), 0);
    check("rst_ovfSticky", int'(ovfSticky), 0);
    check("rst_shift", int'(shiftActive), 0);

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].e, vecs[i].a, 1'b0);
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      check($sformatf("vec%0d_rdValid", i), int'(rdValid),
            int'(vecs[i].head >= 0));
      if (vecs[i].head >= 0)
        check($sformatf("vec%0d_rdData", i), int'(rdData), vecs[i].head);
    end
    check("vec_errSticky", int'(errSticky), 1);

    // Basic make/break, then pop
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    check("mk_count", int'(count), 1);
    check("mk_rdData", int'(rdData), 32'h41 + LC);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("mk_pop_rdValid", int'(rdValid), 0);

`ifdef PS2_KBD_SHIFT_EN
    // Shifted and unshifted letter
    do_reset();
    send(8'h12);
    check("sh_active", int'(shiftActive), 1);
    send(8'h32); send(8'hF0); send(8'h12);
    check("sh_released", int'(shiftActive), 0);
    send(8'h32);
    check("sh_count", int'(count), 2);
    check("sh_head0", int'(rdData), 32'h42);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("sh_head1", int'(rdData), 32'h62);
`endif

    // Extended make and extended break are discarded
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_empty", int'(count), 0);
    send(8'h45);
    check("ext_count", int'(count), 1);
    check("ext_rdData", int'(rdData), 32'h30);
    send(8'h1C);
    check("ext_idle_count", int'(count), 2);

    // Overflow and push-with-pop at full
    do_reset();
    for (int i = 0; i <= DEPTH; i++) send(letter_codes[i]);
    check("ovf_count", int'(count), DEPTH);
    check("ovf_sticky", int'(ovfSticky), 1);
    check("ovf_head", int'(rdData), 32'h41 + LC);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", int'(ovfSticky), 0);
    drive(1'b1, letter_codes[9], 1'b0, 1'b1, 1'b0);
    check("full_pp_count", int'(count), DEPTH);
    check("full_pp_ovf", int'(ovfSticky), 0);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("ovf_data%0d", i), int'(rdData), 32'h41 + i + LC);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check("ovf_last", int'(rdData), 32'h4A + LC);

    // Error byte resets a pending break prefix
    do_reset();
    send(8'hF0);
    drive(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    check("err_empty", int'(count), 0);
    send(8'h1C);
    check("err_sticky", int'(errSticky), 1);
    check("err_count", int'(count), 1);
    check("err_rdData", int'(rdData), 32'h41 + LC);
    drive(1'b1, 8'h29, 1'b1, 1'b0, 1'b1);
    check("err_set_wins", int'(errSticky), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("err_clr_err", int'(errSticky), 0);
    check("err_clr_ovf", int'(ovfSticky), 0);

    // Reset mid-sequence forgets the break prefix and the FIFO contents
    do_reset();
    send(8'h1C); send(8'hF0);
    do_reset();
    check("rmid_empty", int'(count), 0);
    check("rmid_rdValid", int'(rdValid), 0);
    send(8'h16);
    check("rmid_count", int'(count), 1);
    check("rmid_rdData", int'(rdData), 32'h31);

    // Randomized phase against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, e, a, c;
      logic [7:0] b;
      int sel;
      compare_model();
      v = ($urandom_range(0, 9) < 6);
      e = ($urandom_range(0, 15) == 0);
      a = (cyc % 600 < 300) ? ($urandom_range(0, 9) < 2)
                            : ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 31) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        int k;
        k = $urandom_range(0, 38);
        if (k < 26)       b = letter_codes[k];
        else if (k < 36)  b = digit_codes[k - 26];
        else if (k == 36) b = 8'h29;
        else if (k == 37) b = 8'h5A;
        else              b = 8'h66;
      end else if (sel == 5) b = 8'hE0;
      else if (sel == 6)     b = 8'hF0;
      else if (sel == 7)     b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
      else if (sel == 8)     b = 8'($urandom_range(0, 255));
      else                   b = 8'h75;
      model_step(v, b, e, a, c);
      drive(v, b, e, a, c);
    end
    compare_model();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
